// File: rtl/prbs_payload_gen.sv
// ---------------------------------------------------------------------------
// prbs_payload_gen
//   Frames a stream of pseudo-random payload bytes taken from a companion LFSR.
//   A frame is requested with i_start (seed and byte length sampled together).
//   The generator reseeds the LFSR for one cycle, then presents the LFSR's
//   low byte with a valid/ready handshake. The LFSR advances exactly once per
//   accepted byte, so the byte sequence does not depend on downstream stalls.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start, i_abort    frame request / frame termination
//   i_seed, i_length    frame seed and byte count, sampled with i_start
//   o_lfsr_rst_seed     load o_lfsr_seed_data into the LFSR
//   o_lfsr_enable       step the LFSR (one step per accepted byte)
//   o_lfsr_seed_data    latched frame seed
//   i_lfsr_data         current LFSR state
//   o_data/o_valid      payload byte and its qualifier
//   i_ready             downstream accepts o_data
//   o_last              o_data is the final byte of the frame
//   o_busy              frame in progress
//   o_done              one-cycle pulse on normal completion
//   o_byte_count        bytes accepted in the current/last frame
// ---------------------------------------------------------------------------
module prbs_payload_gen #(
    parameter int LFSR_BITS = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [LFSR_BITS-1:0] i_seed,
    input  logic [LEN_WIDTH-1:0] i_length,
    output logic                 o_lfsr_rst_seed,
    output logic                 o_lfsr_enable,
    output logic [LFSR_BITS-1:0] o_lfsr_seed_data,
    input  logic [LFSR_BITS-1:0] i_lfsr_data,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [LEN_WIDTH-1:0] o_byte_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEED   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 in_stream;
    logic                 last;
    logic                 handshake;
    logic                 unused_lfsr_hi;

    // Only the low byte of the LFSR forms the payload.
    assign unused_lfsr_hi = ^i_lfsr_data[LFSR_BITS-1:8];

    assign in_stream = (state_q == ST_STREAM);
    // len_q is never zero in STREAM, so len_q-1 cannot underflow; the counter
    // tops out at len_q and therefore never wraps within a frame.
    assign last      = in_stream && (o_byte_count == (len_q - LEN_ONE));
    // Abort wins over a coincident handshake: no LFSR step, no count.
    assign handshake = in_stream && i_ready && !i_abort;

    assign o_lfsr_rst_seed = (state_q == ST_SEED);
    assign o_lfsr_enable   = handshake;
    assign o_valid         = in_stream;
    assign o_data          = in_stream ? i_lfsr_data[7:0] : 8'h00;
    assign o_last          = last;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = (i_length != '0) ? ST_SEED : ST_DONE;
                end
            end
            ST_SEED: begin
                state_d = i_abort ? ST_IDLE : ST_STREAM;
            end
            ST_STREAM: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (handshake && last) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= ST_IDLE;
            len_q            <= '0;
            o_lfsr_seed_data <= '0;
            o_byte_count     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && i_start) begin
                o_byte_count <= '0;
                // A zero-length frame leaves seed and length untouched.
                if (i_length != '0) begin
                    o_lfsr_seed_data <= i_seed;
                    len_q            <= i_length;
                end
            end else if (handshake) begin
                o_byte_count <= o_byte_count + LEN_ONE;
            end
        end
    end

endmodule

// File: tb/tb_prbs_payload_gen.sv
module tb_prbs_payload_gen;

    localparam int LB = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b0;
    logic [LB-1:0] seed = '0;
    logic [LW-1:0] length = '0;

    logic          rst_seed, enable, valid, last, busy, done;
    logic [LB-1:0] seed_data;
    logic [LB-1:0] lfsr;
    logic [7:0]    data;
    logic [LW-1:0] byte_count;

    int checks = 0;
    int errors = 0;

    prbs_payload_gen #(.LFSR_BITS(LB), .LEN_WIDTH(LW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_abort         (abort),
        .i_seed          (seed),
        .i_length        (length),
        .o_lfsr_rst_seed (rst_seed),
        .o_lfsr_enable   (enable),
        .o_lfsr_seed_data(seed_data),
        .i_lfsr_data     (lfsr),
        .o_data          (data),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_last          (last),
        .o_busy          (busy),
        .o_done          (done),
        .o_byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    // Companion LFSR: 32-bit XNOR, taps 32,22,2,1, shifting left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        lfsr <= '0;
        else if (rst_seed) lfsr <= seed_data;
        else if (enable)   lfsr <= {lfsr[30:0], ~(lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0])};
    end

    typedef struct {
        logic [LB-1:0] seed;
        logic [LW-1:0] len;
        bit            toggle;
        logic [7:0]    exp [0:9];
    } vec_t;

    vec_t vecs [0:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one frame from IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int   got = 0, en_cnt = 0, rs_cnt = 0, both = 0, done_cnt = 0;
        bit   stalled = 0, ph = 1;
        logic [7:0] held = '0;
        logic       held_last = 1'b0;
        @(negedge clk);
        seed = v.seed; length = v.len; start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && done_cnt == 0; cyc++) begin
            ready = v.toggle ? ph : 1'b1;
            ph = ~ph;
            #1;
            if (rst_seed) rs_cnt++;
            if (enable) en_cnt++;
            if (rst_seed && enable) both++;
            if (stalled && valid) begin
                check({tag, " stall_data"}, {24'h0, data}, {24'h0, held});
                check({tag, " stall_last"}, {31'h0, last}, {31'h0, held_last});
            end
            if (valid && ready) begin
                check({tag, " data"}, {24'h0, data}, (got < 10) ? {24'h0, v.exp[got]} : 32'hx);
                check({tag, " last"}, {31'h0, last}, {31'h0, (got == int'(v.len) - 1)});
                got++;
                stalled = 0;
            end else if (valid) begin
                held = data; held_last = last; stalled = 1;
            end
            if (done) begin
                done_cnt++;
                check({tag, " done_count"}, {16'h0, byte_count}, {16'h0, v.len});
            end
            @(negedge clk);
        end
        ready = 1'b0;
        #1;
        check({tag, " done_seen"}, done_cnt, 1);
        check({tag, " bytes"}, got, int'(v.len));
        check({tag, " enables"}, en_cnt, int'(v.len));
        check({tag, " rst_seeds"}, rs_cnt, 1);
        check({tag, " overlap"}, both, 0);
        check({tag, " done_one_cycle"}, {31'h0, done}, 32'h0);
        check({tag, " idle_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{seed: 32'h0, len: 16'd5, toggle: 1'b0,
                    exp: '{8'h00, 8'h01, 8'h02, 8'h04, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{seed: 32'h0, len: 16'd5, toggle: 1'b1,
                    exp: '{8'h00, 8'h01, 8'h02, 8'h04, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{seed: 32'h1, len: 16'd10, toggle: 1'b0,
                    exp: '{8'h01, 8'h02, 8'h04, 8'h09, 8'h12, 8'h24, 8'h49, 8'h92, 8'h24, 8'h49}};
        vecs[3] = '{seed: 32'hFFFF_FFFF, len: 16'd3, toggle: 1'b1,
                    exp: '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{seed: 32'h0, len: 16'd1, toggle: 1'b0,
                    exp: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        // Reset state
        #1;
        check("rst busy", {31'h0, busy}, 0);
        check("rst valid", {31'h0, valid}, 0);
        check("rst done", {31'h0, done}, 0);
        check("rst rst_seed", {31'h0, rst_seed}, 0);
        check("rst enable", {31'h0, enable}, 0);
        check("rst count", {16'h0, byte_count}, 0);
        check("rst seed_data", seed_data, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Zero-length frame: straight to DONE, no seed load, no bytes.
        @(negedge clk);
        seed = 32'h5; length = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; #1;
        check("len0 done", {31'h0, done}, 1);
        check("len0 valid", {31'h0, valid}, 0);
        check("len0 rst_seed", {31'h0, rst_seed}, 0);
        check("len0 count", {16'h0, byte_count}, 0);
        check("len0 seed_kept", seed_data, 32'h0);
        @(negedge clk); #1;
        check("len0 done_clear", {31'h0, done}, 0);
        check("len0 idle", {31'h0, busy}, 0);

        // Abort after two accepted bytes of a 10-byte frame.
        @(negedge clk);
        seed = 32'h0; length = 16'd10; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;        // SEED
        @(negedge clk);                      // byte 0 accepted at next edge
        @(negedge clk);                      // byte 1 accepted at next edge
        @(negedge clk);
        abort = 1'b1; #1;
        check("abort valid", {31'h0, valid}, 1);
        check("abort no_enable", {31'h0, enable}, 0);
        @(negedge clk);
        abort = 1'b0; ready = 1'b0; #1;
        check("abort idle", {31'h0, busy}, 0);
        check("abort count", {16'h0, byte_count}, 2);
        begin
            int dn = 0;
            for (int i = 0; i < 4; i++) begin
                if (done) dn++;
                @(negedge clk); #1;
            end
            check("abort no_done", dn, 0);
        end
        // Abort in IDLE does nothing harmful
        abort = 1'b1; #1;
        check("abort idle_noeffect", {31'h0, busy}, 0);
        @(negedge clk); abort = 1'b0;
        run_vec(vecs[0], "after_abort");

        // i_start during STREAM with a different seed/length is ignored.
        @(negedge clk);
        seed = 32'h0; length = 16'd5; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin start = 1'b1; seed = 32'h1; length = 16'd10; end
            else start = 1'b0;
            #1;
            check("restart data", {24'h0, data}, {24'h0, vecs[0].exp[i]});
            check("restart last", {31'h0, last}, {31'h0, (i == 4)});
        end
        @(negedge clk); ready = 1'b0; #1;
        check("restart done", {31'h0, done}, 1);
        check("restart count", {16'h0, byte_count}, 5);
        @(negedge clk);

        // Reset mid-STREAM.
        seed = 32'h0; length = 16'd5; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        check("mrst valid", {31'h0, valid}, 0);
        check("mrst busy", {31'h0, busy}, 0);
        check("mrst data", {24'h0, data}, 0);
        check("mrst enable", {31'h0, enable}, 0);
        check("mrst count", {16'h0, byte_count}, 0);
        check("mrst seed_data", seed_data, 0);
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b0;
        begin
            int dn = 0;
            for (int i = 0; i < 6; i++) begin
                #1; if (done || busy) dn++;
                @(negedge clk);
            end
            check("mrst quiet", dn, 0);
        end
        run_vec(vecs[2], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
